spi_count_sequencer: RTL and testbench

SPI_COUNT_SEQUENCER -- requirements
Module: spi_count_sequencer

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_count_sequencer_tick_gen.sv | 53 +++++
 rtl/spi_count_sequencer.sv | 166 ++++++++++++++++
 tb/tb_spi_count_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI count sequencer:
//                frame-state encoding, byte and count widths, and helpers
//                that split a count value into its two transmitted bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 14;

  // Frame sequencing states; SS_n is low in every state except IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SEND_HI  = 3'd2,
    WAIT_HI  = 3'd3,
    SEND_LO  = 3'd4,
    WAIT_LO  = 3'd5,
    CS_HOLD  = 3'd6
  } frame_state_e;

  // Upper byte of a count, zero-padded above the count width.
  function automatic logic [BYTE_W-1:0] hi_byte(input logic [CNT_W-1:0] v);
    return {{(2*BYTE_W-CNT_W){1'b0}}, v[CNT_W-1:BYTE_W]};
  endfunction

  // Lower byte of a count.
  function automatic logic [BYTE_W-1:0] lo_byte(input logic [CNT_W-1:0] v);
    return v[BYTE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_count_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler. Counts enabled clock cycles and
//                emits a one-cycle tick on the cycle the counter wraps from
//                TICK_CYCLES-1 back to 0. Holds its value while disabled;
//                a clear zeroes it and suppresses a coincident tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  // Tick fires on the enabled wrap cycle; a clear in the same cycle wins.
  assign tick = en & at_last & ~clr;

  // Next counter value: clear, advance-with-wrap while enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_count_sequencer
//  Description : Run/stop decimal-style up-counter that publishes every new
//                value over SPI as a two-byte frame (high byte first) framed
//                by an active-low slave select. Count changes seen while a
//                frame is in flight collapse into a single follow-up frame
//                carrying the most recent value.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_count_sequencer
  import spi_pkg::*;
#(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int CNT_MAX     = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_runstop,
  input  logic              btn_clear,
  input  logic              spi_ready,
  input  logic              spi_done,
  output logic              spi_start,
  output logic [BYTE_W-1:0] spi_tx_data,
  output logic              SS_n,
  output logic              running,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Run state and clear edge detection.
  logic              running_q,  running_d;
  logic              clr_prev_q, clr_prev_d;
  logic              clr_pulse;

  // Count datapath and change tracking.
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              pending_q,  pending_d;
  logic              cnt_change;
  logic              tick;

  // Frame sequencer.
  frame_state_e      state_q,    state_d;
  logic [CNT_W-1:0]  snap_q,     snap_d;
  logic [BYTE_W-1:0] tx_q,       tx_d;
  logic              ss_n_q,     ss_n_d;
  logic              frame_take;

  // A clear request is the rising edge of the debounced button level.
  assign clr_pulse = btn_clear & ~clr_prev_q;

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (running_q),
    .clr   (clr_pulse),
    .tick  (tick)
  );

  // Count update: clear beats increment; every update (even clear at 0)
  // marks the value as needing publication.
  always_comb begin
    running_d  = btn_runstop;
    clr_prev_d = btn_clear;
    count_d    = count_q;
    cnt_change = 1'b0;
    if (clr_pulse) begin
      count_d    = '0;
      cnt_change = 1'b1;
    end else if (tick) begin
      count_d    = (count_q == CNT_LAST) ? '0 : count_q + CNT_ONE;
      cnt_change = 1'b1;
    end
    // A change in the same cycle the sequencer takes a snapshot must stay
    // pending, since the snapshot holds the pre-change value.
    pending_d = (pending_q & ~frame_take) | cnt_change;
  end

  // Frame sequencer next-state and outputs.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    tx_d       = tx_q;
    frame_take = 1'b0;
    spi_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d    = CS_SETUP;
          snap_d     = count_q;
          frame_take = 1'b1;
        end
      end
      CS_SETUP: begin
        state_d = SEND_HI;
        tx_d    = hi_byte(snap_q);
      end
      SEND_HI: begin
        if (spi_ready) begin
          spi_start = 1'b1;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (spi_done) begin
          state_d = SEND_LO;
          tx_d    = lo_byte(snap_q);
        end
      end
      SEND_LO: begin
        if (spi_ready) begin
          spi_start = 1'b1;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (spi_done) begin
          state_d = CS_HOLD;
        end
      end
      CS_HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Slave select is deasserted only while idle; registering it from the
    // next state keeps it glitch-free and aligned with the state register.
    ss_n_d = (state_d == IDLE);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      state_q    <= IDLE;
      snap_q     <= '0;
      tx_q       <= '0;
      ss_n_q     <= 1'b1;
    end else begin
      running_q  <= running_d;
      clr_prev_q <= clr_prev_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      snap_q     <= snap_d;
      tx_q       <= tx_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign running     = running_q;
  assign count       = count_q;
  assign SS_n        = ss_n_q;
  assign spi_tx_data = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_count_sequencer
//  Description : Self-checking bench for spi_count_sequencer. A cycle-level
//                reference model of the count rules and a frame monitor
//                check every published frame; a second fast-ticking instance
//                reaches the large count values quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_count_sequencer;

  localparam int TICK = 10;
  localparam int CMAX = 9999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals.
  logic        rst_n;
  logic        btn_runstop;
  logic        btn_clear;
  logic        spi_ready;
  logic        spi_done;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        ss_n;
  logic        running;
  logic [13:0] count;

  // Fast instance signals (one tick per running cycle).
  logic        btn_runstop_f = 1'b0;
  logic        btn_clear_f   = 1'b0;
  logic        spi_ready_f   = 1'b1;
  logic        spi_done_f    = 1'b0;
  logic        spi_start_f;
  logic [7:0]  tx_f;
  logic        ss_n_f;
  logic        running_f;
  logic [13:0] count_f;

  spi_count_sequencer #(.TICK_CYCLES(TICK), .CNT_MAX(CMAX)) dut (
    .clk(clk), .rst_n(rst_n), .btn_runstop(btn_runstop), .btn_clear(btn_clear),
    .spi_ready(spi_ready), .spi_done(spi_done), .spi_start(spi_start),
    .spi_tx_data(spi_tx_data), .SS_n(ss_n), .running(running), .count(count)
  );

  spi_count_sequencer #(.TICK_CYCLES(1), .CNT_MAX(CMAX)) dut_fast (
    .clk(clk), .rst_n(rst_n), .btn_runstop(btn_runstop_f), .btn_clear(btn_clear_f),
    .spi_ready(spi_ready_f), .spi_done(spi_done_f), .spi_start(spi_start_f),
    .spi_tx_data(tx_f), .SS_n(ss_n_f), .running(running_f), .count(count_f)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model of the count rules ----------------
  logic        m_running;
  logic        m_clr_prev;
  int          m_phase;
  logic [13:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running  <= 1'b0;
      m_clr_prev <= 1'b0;
      m_phase    <= 0;
      m_count    <= '0;
    end else begin
      m_running  <= btn_runstop;
      m_clr_prev <= btn_clear;
      if (btn_clear && !m_clr_prev) begin
        m_phase <= 0;
        m_count <= '0;
      end else if (m_running) begin
        if (m_phase == TICK - 1) begin
          m_phase <= 0;
          m_count <= 14'((int'(m_count) + 1) % (CMAX + 1));
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  // ---------------- frame monitor (samples on falling edge) ----------------
  logic        prev_ss    = 1'b1;
  logic        prev_start = 1'b0;
  logic        start_seen = 1'b0;
  int          in_frame   = 0;
  int          nbytes     = 0;
  int          frame_cnt  = 0;
  logic [7:0]  b0, b1, cur_byte;
  logic [13:0] snap;
  logic [13:0] m_count_prev = '0;
  logic [13:0] last_val     = '0;
  logic [13:0] fr_q[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_ss = 1'b1; prev_start = 1'b0; start_seen = 1'b0;
      in_frame = 0; nbytes = 0; m_count_prev = '0;
    end else begin
      check_eq("count", count, m_count);
      check_eq("running", running, m_running);
      if (spi_start) begin
        check_eq("start_cs", ss_n, 1'b0);
        check_eq("start_1cyc", prev_start, 1'b0);
        if (nbytes == 0) b0 = spi_tx_data; else b1 = spi_tx_data;
        cur_byte = spi_tx_data;
        nbytes++;
      end
      if (spi_done && in_frame != 0) check_eq("tx_hold", spi_tx_data, cur_byte);
      if (prev_ss && !ss_n) begin
        in_frame = 1; nbytes = 0; snap = m_count_prev;
      end else if (!prev_ss && ss_n) begin
        check_eq("frame_len", nbytes, 2);
        check_eq("frame_hi", b0, 8'(snap >> 8));
        check_eq("frame_lo", b1, 8'(snap & 14'h00FF));
        in_frame = 0;
        frame_cnt++;
        last_val = snap;
        fr_q.push_back(snap);
      end
      start_seen   = spi_start;
      prev_ss      = ss_n;
      prev_start   = spi_start;
      m_count_prev = m_count;
    end
  end

  // ---------------- SPI master model for the main instance ----------------
  int spi_len = 16;
  int busy    = 0;

  initial begin
    spi_ready = 1'b1;
    spi_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        spi_ready = 1'b1; spi_done = 1'b0; busy = 0;
      end else begin
        spi_done = 1'b0;
        if (start_seen) begin
          spi_ready = 1'b0;
          busy      = spi_len;
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            spi_ready = 1'b1;
            spi_done  = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- fast instance: always-ready master ----------------
  logic       f_seen = 1'b0;
  logic [7:0] f_prev = '0;
  logic [7:0] f_last = '0;

  initial forever begin
    @(negedge clk);
    f_seen = rst_n && spi_start_f;
    if (f_seen) begin
      f_prev = f_last;
      f_last = tx_f;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    spi_done_f = f_seen;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_fast(input int n);
    btn_runstop_f = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    btn_runstop_f = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          frames0;
    int          seen;
    int          hit;
    logic [13:0] prev_c;

    rst_n = 1'b0; btn_runstop = 1'b0; btn_clear = 1'b0;
    cycles(3);
    check_eq("rst_ss", ss_n, 1'b1);
    check_eq("rst_start", spi_start, 1'b0);
    check_eq("rst_tx", spi_tx_data, 8'h00);
    check_eq("rst_run", running, 1'b0);
    check_eq("rst_cnt", count, 14'd0);
    rst_n = 1'b1;
    cycles(5);
    check_eq("idle_no_frame", frame_cnt, 0);

    // Run 35 cycles with a quick master: three frames 1, 2, 3.
    spi_len = 2;
    fr_q.delete();
    btn_runstop = 1'b1;
    cycles(35);
    btn_runstop = 1'b0;
    cycles(60);
    check_eq("run35_count", count, 14'd3);
    check_eq("run35_frames", fr_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq("run35_value", (i < fr_q.size()) ? 32'(fr_q[i]) : 32'hFFFF, i + 1);

    // Stop for 50 cycles: frozen, no frames; resume finishes the tick.
    spi_len = 16;
    frames0 = frame_cnt;
    cycles(50);
    check_eq("stop_frozen", count, 14'd3);
    check_eq("stop_no_frame", frame_cnt - frames0, 0);
    btn_runstop = 1'b1;
    cycles(5);
    check_eq("resume_early", count, 14'd3);
    cycles(1);
    check_eq("resume_tick", count, 14'd4);

    // Clear landing on the same edge as a tick wrap.
    hit = 0;
    for (int k = 0; k < 30; k++) begin
      cycles(1);
      if (m_running && btn_runstop && m_phase == TICK - 1) begin
        btn_clear = 1'b1;
        hit = 1;
        break;
      end
    end
    check_eq("clr_tick_found", hit, 1);
    cycles(1);
    check_eq("clr_vs_tick", count, 14'd0);
    btn_clear = 1'b0;

    // Clear while stopped at zero still publishes one frame of zero.
    btn_runstop = 1'b0;
    cycles(1);
    btn_clear = 1'b1;
    cycles(1);
    btn_clear = 1'b0;
    cycles(150);
    frames0 = frame_cnt;
    btn_clear = 1'b1;
    cycles(1);
    btn_clear = 1'b0;
    cycles(150);
    check_eq("clr0_frames", frame_cnt - frames0, 1);
    check_eq("clr0_value", last_val, 14'd0);

    // Randomised run/stop/clear activity with varying master latency.
    for (int k = 0; k < 600; k++) begin
      if (k % 100 == 0) spi_len = $urandom_range(2, 20);
      cycles(1);
      if ($urandom_range(0, 19) == 0) btn_runstop = ~btn_runstop;
      if ($urandom_range(0, 24) == 0) btn_clear = ~btn_clear;
    end
    btn_runstop = 1'b0;
    btn_clear   = 1'b0;
    cycles(200);
    check_eq("rand_final_frame", last_val, m_count);

    // Slow master: four ticks, three of them inside the first frame.
    spi_len = 40;
    frames0 = frame_cnt;
    btn_runstop = 1'b1;
    seen = 0;
    prev_c = m_count;
    for (int k = 0; k < 200 && seen < 4; k++) begin
      cycles(1);
      if (m_count != prev_c) begin
        seen++;
        prev_c = m_count;
      end
    end
    btn_runstop = 1'b0;
    check_eq("coal_ticks", seen, 4);
    cycles(300);
    check_eq("coal_frames", frame_cnt - frames0, 2);
    check_eq("coal_last", last_val, m_count);

    // Fast instance: reach 0x1234, then 9999, then wrap to 0.
    run_fast(4660);
    cycles(20);
    check_eq("fast_1234_cnt", count_f, 14'h1234);
    check_eq("fast_1234_hi", f_prev, 8'h12);
    check_eq("fast_1234_lo", f_last, 8'h34);
    run_fast(CMAX - 4660);
    cycles(20);
    check_eq("fast_max_cnt", count_f, 14'd9999);
    check_eq("fast_max_hi", f_prev, 8'h27);
    check_eq("fast_max_lo", f_last, 8'h0F);
    run_fast(1);
    cycles(20);
    check_eq("fast_wrap_cnt", count_f, 14'd0);
    check_eq("fast_wrap_hi", f_prev, 8'h00);
    check_eq("fast_wrap_lo", f_last, 8'h00);
    check_eq("fast_ss_idle", ss_n_f, 1'b1);
    check_eq("fast_stopped", running_f, 1'b0);

    // Reset during the low-byte transfer aborts the frame at once.
    spi_len = 16;
    btn_runstop = 1'b1;
    hit = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #2;
      if (in_frame != 0 && nbytes == 2 && !spi_ready) begin
        hit = 1;
        break;
      end
    end
    check_eq("rst_wait_lo_found", hit, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ss", ss_n, 1'b1);
    check_eq("rst_mid_start", spi_start, 1'b0);
    check_eq("rst_mid_cnt", count, 14'd0);
    check_eq("rst_mid_run", running, 1'b0);
    check_eq("rst_mid_tx", spi_tx_data, 8'h00);
    btn_runstop = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    frames0 = frame_cnt;
    cycles(60);
    check_eq("post_rst_no_frame", frame_cnt - frames0, 0);
    check_eq("post_rst_ss", ss_n, 1'b1);
    check_eq("post_rst_cnt", count, 14'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
